// File: rtl/vblank_access_scheduler_pkg.sv
// Shared types and widths for the vblank memory access scheduler.
// The state encoding and counter widths are common to the top and its selector.
package vblank_access_scheduler_pkg;

   typedef enum logic [1:0] {
      DISPLAY = 2'd0,
      ARB     = 2'd1,
      GRANT   = 2'd2
   } state_e;

   localparam int HOLD_W  = 10;
   localparam int DIV_W   = 8;
   localparam int FRAME_W = 8;
   localparam int PTR_W   = 2;
   localparam int MAX_REQ = 4;

   // Index of the set bit in a one-hot (or zero) grant vector.
   function automatic logic [PTR_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      if (oh[1])      idx = 2'd1;
      else if (oh[2]) idx = 2'd2;
      else if (oh[3]) idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/vblank_access_scheduler_if.sv
// Request/release/grant bundle between game-logic requesters and the scheduler.
// master = requester side, slave = scheduler side.
interface vblank_access_scheduler_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] gnt;

   modport master (output req, output done, input gnt);
   modport slave  (input req, input done, output gnt);
endinterface

// File: rtl/vblank_access_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester at or above the pointer,
// wrapping to the lowest requester when none is found above it.
module vblank_access_scheduler_rr_pick
   import vblank_access_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic               valid_o
);

   logic [NUM_REQ-1:0] ge_mask;
   logic [NUM_REQ-1:0] upper;

   // x & (~x + 1) isolates the lowest set bit of x.
   always_comb begin
      ge_mask = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
      upper   = req_i & ge_mask;
      if (|upper) pick_o = upper & (~upper + NUM_REQ'(1));
      else        pick_o = req_i & (~req_i + NUM_REQ'(1));
      valid_o = |req_i;
   end

endmodule

// File: rtl/vblank_access_scheduler.sv
// Shares game-state memory between the display path (visible region) and
// round-robin game-logic requesters (vertical blanking); also paces the game tick.
module vblank_access_scheduler
   import vblank_access_scheduler_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int TICK_DIV = 8,
   parameter int MAX_HOLD = 64
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       v_visable,
   vblank_access_scheduler_if.slave   bus,
   output logic                       disp_owner,
   output logic                       game_tick,
   output logic [FRAME_W-1:0]         frame_cnt,
   output logic                       overrun,
   output logic                       timeout
);

   logic               v_s1_q, v_s2_q, v_prev_q;
   logic               vb_start, vb_end, done_g;
   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
   logic               pick_vld;
   logic [PTR_W-1:0]   ptr_q, ptr_d, gidx, adv_ptr;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               disp_q, disp_d, tick_q, tick_d;
   logic               ovr_q, ovr_d, to_q, to_d;

   vblank_access_scheduler_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .pick_o  (pick),
      .valid_o (pick_vld)
   );

   // Syncs reset high so a low v_visable at reset release reads as a vblank start.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         v_s1_q   <= 1'b1;
         v_s2_q   <= 1'b1;
         v_prev_q <= 1'b1;
      end else begin
         v_s1_q   <= v_visable;
         v_s2_q   <= v_s1_q;
         v_prev_q <= v_s2_q;
      end
   end

   assign vb_start = v_prev_q & ~v_s2_q;
   assign vb_end   = ~v_prev_q & v_s2_q;
   assign done_g   = |(bus.done & gnt_q);
   assign gidx     = oh_to_idx(MAX_REQ'(gnt_q));
   assign adv_ptr  = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      div_d   = div_q;
      frame_d = frame_q;
      tick_d  = 1'b0;
      ovr_d   = ovr_q;
      to_d    = 1'b0;
      case (state_q)
         DISPLAY: begin
            gnt_d = '0;
            if (vb_start) begin
               state_d = ARB;
               frame_d = frame_q + FRAME_W'(1);
               if (div_q == DIV_W'(TICK_DIV - 1)) begin
                  div_d  = '0;
                  tick_d = 1'b1;
               end else begin
                  div_d  = div_q + DIV_W'(1);
               end
            end
         end
         ARB: begin
            if (vb_end) begin
               state_d = DISPLAY;
               gnt_d   = '0;
            end else if (pick_vld) begin
               state_d = GRANT;
               gnt_d   = pick;
               hold_d  = '0;
            end
         end
         GRANT: begin
            // Window close beats release, which beats the hold limit.
            if (vb_end) begin
               state_d = DISPLAY;
               gnt_d   = '0;
               ptr_d   = adv_ptr;
               if (!done_g) ovr_d = 1'b1;
            end else if (done_g) begin
               state_d = ARB;
               gnt_d   = '0;
               ptr_d   = adv_ptr;
            end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               state_d = ARB;
               gnt_d   = '0;
               ptr_d   = adv_ptr;
               to_d    = 1'b1;
            end else begin
               hold_d  = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = DISPLAY;
            gnt_d   = '0;
         end
      endcase
      disp_d = (state_d == DISPLAY);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= DISPLAY;
         gnt_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         div_q   <= '0;
         frame_q <= '0;
         disp_q  <= 1'b1;
         tick_q  <= 1'b0;
         ovr_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         div_q   <= div_d;
         frame_q <= frame_d;
         disp_q  <= disp_d;
         tick_q  <= tick_d;
         ovr_q   <= ovr_d;
         to_q    <= to_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign disp_owner = disp_q;
   assign game_tick  = tick_q;
   assign frame_cnt  = frame_q;
   assign overrun    = ovr_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// Scoreboard bench: drivers push expected grants/ticks/timeouts from a
// round-robin frame model; a negedge monitor pops and compares DUT events.
module tb_vblank_access_scheduler;

   localparam int NUM_REQ  = 2;
   localparam int TICK_DIV = 8;
   localparam int MAX_HOLD = 64;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       v_visable;
   logic       disp_owner, game_tick, overrun, timeout;
   logic [7:0] frame_cnt;

   vblank_access_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   vblank_access_scheduler #(
      .NUM_REQ(NUM_REQ), .TICK_DIV(TICK_DIV), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .v_visable  (v_visable),
      .bus        (bus),
      .disp_owner (disp_owner),
      .game_tick  (game_tick),
      .frame_cnt  (frame_cnt),
      .overrun    (overrun),
      .timeout    (timeout)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int exp_gnt_q[$];
   int exp_tick_q[$];
   int exp_to_q[$];
   int m_ptr    = 0;
   int m_frames = 0;
   int jobs[NUM_REQ];
   int to_pulses = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++)
         if (((v >> i) & NUM_REQ'(1)) != '0) return i;
      return -1;
   endfunction

   // Reference round-robin choice: first requester from p upward, wrapping.
   function automatic int rr_next(input logic [NUM_REQ-1:0] r, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (p + k) % NUM_REQ;
         if (((r >> i) & NUM_REQ'(1)) != '0) return i;
      end
      return -1;
   endfunction

   // Monitor
   initial begin
      logic [NUM_REQ-1:0] prev_g;
      logic               prev_tick;
      int                 e;
      prev_g    = '0;
      prev_tick = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            prev_g    = '0;
            prev_tick = 1'b0;
         end else begin
            check("gnt_onehot", ($countones(bus.gnt) <= 1) ? 1 : 0, 1);
            check("gnt_while_disp", (bus.gnt != '0 && disp_owner) ? 1 : 0, 0);
            check("dead_cycle", (prev_g != '0 && bus.gnt != '0 && bus.gnt != prev_g) ? 1 : 0, 0);
            if (bus.gnt != '0 && prev_g == '0) begin
               if (exp_gnt_q.size() == 0) check("grant_unexpected", oh_idx(bus.gnt), -1);
               else begin
                  e = exp_gnt_q.pop_front();
                  check("grant_idx", oh_idx(bus.gnt), e);
               end
            end
            if (game_tick) begin
               check("tick_width", int'(prev_tick), 0);
               if (exp_tick_q.size() == 0) check("tick_unexpected", int'(frame_cnt), -1);
               else begin
                  e = exp_tick_q.pop_front();
                  check("tick_frame", int'(frame_cnt), e);
               end
            end
            if (timeout) begin
               to_pulses++;
               if (exp_to_q.size() == 0) check("timeout_unexpected", oh_idx(prev_g), -1);
               else begin
                  e = exp_to_q.pop_front();
                  check("timeout_idx", oh_idx(prev_g), e);
               end
            end
            prev_g    = bus.gnt;
            prev_tick = game_tick;
         end
      end
   end

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic apply_reset();
      RESET     = 1'b1;
      v_visable = 1'b1;
      bus.req   = '0;
      bus.done  = '0;
      for (int i = 0; i < NUM_REQ; i++) jobs[i] = 0;
      tick_n(3);
      check("rst_gnt", int'(bus.gnt), 0);
      check("rst_disp", int'(disp_owner), 1);
      check("rst_frame", int'(frame_cnt), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_tick", int'(game_tick), 0);
      check("rst_timeout", int'(timeout), 0);
      m_ptr    = 0;
      m_frames = 0;
      exp_gnt_q.delete();
      exp_tick_q.delete();
      exp_to_q.delete();
      RESET = 1'b0;
      tick_n(1);
   endtask

   task automatic set_req_from_jobs();
      logic [NUM_REQ-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (jobs[i] > 0) r = r | (NUM_REQ'(1) << i);
      bus.req = r;
   endtask

   task automatic vblank_begin();
      int n;
      v_visable = 1'b0;
      m_frames++;
      if (m_frames % TICK_DIV == 0) exp_tick_q.push_back(m_frames % 256);
      n = rr_next(bus.req, m_ptr);
      if (n >= 0) exp_gnt_q.push_back(n);
   endtask

   task automatic empty_frame();
      vblank_begin();
      tick_n(4);
      v_visable = 1'b1;
      tick_n(5);
   endtask

   task automatic wait_grant(output int g);
      int w;
      w = 0;
      while (bus.gnt == '0 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      if (bus.gnt == '0) begin
         check("grant_wait", 0, 1);
         g = -1;
      end else g = oh_idx(bus.gnt);
   endtask

   // Requester behaviour: hold the grant h cycles then release; h > MAX_HOLD forces a revoke.
   task automatic serve_one(input int h, output int g, output int nvis);
      int k, n;
      wait_grant(g);
      nvis = 0;
      if (g < 0) begin
         bus.req = '0;
         return;
      end
      if (h > MAX_HOLD) exp_to_q.push_back(g);
      k = 1;
      forever begin
         if (bus.gnt == '0) begin
            nvis = k - 1;
            jobs[g]--;
            set_req_from_jobs();
            break;
         end
         if (k == h) begin
            nvis = h;
            bus.done = NUM_REQ'(1) << g;
            jobs[g]--;
            set_req_from_jobs();
            @(negedge CLK);
            bus.done = '0;
            break;
         end
         @(negedge CLK);
         k++;
      end
      m_ptr = (g + 1) % NUM_REQ;
      n = rr_next(bus.req, m_ptr);
      if (n >= 0) exp_gnt_q.push_back(n);
   endtask

   initial begin
      int g, nvis, h, to0;
      RESET     = 1'b1;
      v_visable = 1'b1;
      bus.req   = '0;
      bus.done  = '0;
      apply_reset();

      // 16 empty frames: ticks on the 8th and 16th vblank start
      for (int f = 0; f < 16; f++) empty_frame();
      check("frame_cnt_16", int'(frame_cnt), 16);

      // Both request, pointer 0: grant 0, dead cycle, grant 1
      jobs[0] = 1; jobs[1] = 1;
      set_req_from_jobs();
      vblank_begin();
      serve_one(3, g, nvis);
      check("first_grantee", g, 0);
      check("dead_cycle_gnt", int'(bus.gnt), 0);
      tick_n(1);
      check("second_gnt", int'(bus.gnt), 2);
      serve_one(2, g, nvis);
      check("second_grantee", g, 1);
      tick_n(2);
      v_visable = 1'b1;
      tick_n(6);

      // Hold limit: req[0] never releases, req[1] waits
      jobs[0] = 1; jobs[1] = 1;
      set_req_from_jobs();
      to0 = to_pulses;
      vblank_begin();
      serve_one(200, g, nvis);
      check("to_grantee", g, 0);
      check("hold_len", nvis, MAX_HOLD);
      check("timeout_now", int'(timeout), 1);
      tick_n(1);
      check("after_to_gnt", int'(bus.gnt), 2);
      serve_one(4, g, nvis);
      check("timeout_pulses", to_pulses - to0, 1);
      tick_n(2);
      v_visable = 1'b1;
      tick_n(6);

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < NUM_REQ; i++) jobs[i] = $urandom_range(0, 2);
         set_req_from_jobs();
         vblank_begin();
         while (bus.req != '0) begin
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_HOLD + 1, MAX_HOLD + 6)
                                            : $urandom_range(1, 20);
            serve_one(h, g, nvis);
            if (g < 0) break;
         end
         tick_n($urandom_range(1, 3));
         v_visable = 1'b1;
         tick_n($urandom_range(5, 8));
      end
      check("no_overrun_yet", int'(overrun), 0);

      // Window closes on an active grant: overrun, sticky across frames
      jobs[0] = 1; jobs[1] = 0;
      set_req_from_jobs();
      vblank_begin();
      wait_grant(g);
      v_visable = 1'b1;
      tick_n(2);
      check("close_gnt_held", (bus.gnt != '0) ? 1 : 0, 1);
      tick_n(1);
      check("close_gnt", int'(bus.gnt), 0);
      check("close_disp", int'(disp_owner), 1);
      check("close_overrun", int'(overrun), 1);
      jobs[0] = 0;
      set_req_from_jobs();
      m_ptr = (g + 1) % NUM_REQ;
      tick_n(4);
      empty_frame();
      check("overrun_sticky", int'(overrun), 1);

      // Release coincident with window close: no overrun
      apply_reset();
      jobs[1] = 1;
      set_req_from_jobs();
      vblank_begin();
      wait_grant(g);
      check("coinc_grantee", g, 1);
      v_visable = 1'b1;
      tick_n(2);
      bus.done = 2'b10;
      bus.req  = '0;
      tick_n(1);
      bus.done = '0;
      check("coinc_gnt", int'(bus.gnt), 0);
      check("coinc_disp", int'(disp_owner), 1);
      check("coinc_overrun", int'(overrun), 0);
      tick_n(3);

      // frame_cnt wrap and reset mid-grant
      apply_reset();
      for (int f = 0; f < 255; f++) empty_frame();
      check("frame_cnt_255", int'(frame_cnt), 255);
      empty_frame();
      check("frame_cnt_wrap", int'(frame_cnt), 0);
      jobs[0] = 1;
      set_req_from_jobs();
      vblank_begin();
      wait_grant(g);
      check("pre_rst_grantee", g, 0);
      RESET     = 1'b1;
      v_visable = 1'b1;
      bus.req   = '0;
      tick_n(1);
      check("rst_mid_gnt", int'(bus.gnt), 0);
      check("rst_mid_timeout", int'(timeout), 0);
      check("rst_mid_overrun", int'(overrun), 0);
      apply_reset();
      tick_n(2);
      check("post_rst_timeout", int'(timeout), 0);

      check("grant_q_empty", exp_gnt_q.size(), 0);
      check("tick_q_empty", exp_tick_q.size(), 0);
      check("timeout_q_empty", exp_to_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
